// File: rtl/tcb_pkg.sv
// Shared TCB package.
//   tcb_par_t  : bus parameter bundle (address / data width)
//   tcb_sts_t  : response status carried on err
//   GPIO_*     : byte offsets of the GPIO register map (decoded on adr[3:2])
package tcb_pkg;

  typedef struct packed {
    int unsigned adr;
    int unsigned dat;
  } tcb_par_t;

  localparam tcb_par_t TCB_PAR_DEF = '{adr: 32, dat: 32};

  typedef enum logic {
    TCB_OKAY  = 1'b0,
    TCB_ERROR = 1'b1
  } tcb_sts_t;

  localparam logic [3:0] GPIO_OUT = 4'h0;
  localparam logic [3:0] GPIO_ENA = 4'h4;
  localparam logic [3:0] GPIO_INP = 4'h8;
  localparam logic [3:0] GPIO_RSV = 4'hC;

endpackage

// File: rtl/tcb_gpio_sync.sv
// Multi-stage input synchronizer for the GPIO pad inputs.
//   clk, rst : clock, asynchronous active-low reset (clears every stage)
//   d        : asynchronous pad values
//   q        : value after CFG_CDC flops; CFG_CDC = 0 passes d straight through
module tcb_gpio_sync #(
  parameter int    GW      = 32,
  parameter int    CFG_CDC = 2,
  parameter string CHIP    = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [GW-1:0] d,
  output logic [GW-1:0] q
);

  // No vendor synchronizer primitives exist in this slice, so every CHIP
  // target maps onto the same generic flop chain.
  logic unused_chip;
  assign unused_chip = (CHIP == "");

  if (CFG_CDC == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [GW-1:0] stg [CFG_CDC];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < CFG_CDC; i++) stg[i] <= '0;
      end else begin
        stg[0] <= d;
        for (int i = 1; i < CFG_CDC; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[CFG_CDC-1];
  end

endmodule

// File: rtl/tcb_gpio.sv
// GPIO peripheral on a TCB half-duplex bus.
//   clk, rst       : clock, asynchronous active-low reset
//   vld/wen/adr/ben/wdt : TCB request (transfer on vld & rdy)
//   rdy            : always 1, no back-pressure
//   rdt/err        : registered response, valid one cycle after the transfer
//   gpio_o/gpio_e  : output value / output enable registers
//   gpio_i         : pad inputs, read through the synchronizer at 0x08
// Handshake: a request is taken on every rising edge where vld & rdy = 1;
// its response (rdt for reads, err for both) is presented the following cycle.
module tcb_gpio
  import tcb_pkg::*;
#(
  parameter int    GW      = 32,
  parameter int    ADR     = 32,
  parameter int    DAT     = 32,
  parameter int    CFG_CDC = 2,
  parameter int    CFG_MIN = 0,
  parameter string CHIP    = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld,
  input  logic             wen,
  input  logic [ADR-1:0]   adr,
  input  logic [DAT/8-1:0] ben,
  input  logic [DAT-1:0]   wdt,
  output logic             rdy,
  output logic [DAT-1:0]   rdt,
  output logic             err,
  output logic [GW-1:0]    gpio_o,
  output logic [GW-1:0]    gpio_e,
  input  logic [GW-1:0]    gpio_i
);

  localparam int BEN = DAT/8;

  logic [GW-1:0]  out_r, ena_r, inp_s;
  logic [1:0]     sel;
  logic           trn;
  logic [DAT-1:0] wmask;
  logic [GW-1:0]  out_nxt, ena_nxt;
  logic [DAT-1:0] rd_val;
  logic           bad;
  tcb_sts_t       sts_r;

  // Only adr[3:2] decodes; the rest of the address aliases.
  logic unused_adr;
  assign unused_adr = ^{adr[ADR-1:4], adr[1:0]};

  assign rdy = 1'b1;
  assign trn = vld & rdy;
  assign sel = adr[3:2];

  tcb_gpio_sync #(
    .GW      (GW),
    .CFG_CDC (CFG_CDC),
    .CHIP    (CHIP)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (gpio_i),
    .q   (inp_s)
  );

  // Byte-lane write mask; minimal configuration writes full words only.
  always_comb begin
    wmask = '0;
    for (int b = 0; b < BEN; b++)
      wmask[8*b +: 8] = {8{ben[b] | (CFG_MIN != 0)}};
  end

  // Merge in the DAT domain, then drop bits at or above GW.
  assign out_nxt = GW'((DAT'(out_r) & ~wmask) | (wdt & wmask));
  assign ena_nxt = GW'((DAT'(ena_r) & ~wmask) | (wdt & wmask));

  always_comb begin
    rd_val = '0;
    case (sel)
      GPIO_OUT[3:2]: rd_val = DAT'(out_r);
      GPIO_ENA[3:2]: rd_val = DAT'(ena_r);
      GPIO_INP[3:2]: rd_val = DAT'(inp_s);
      default:       rd_val = '0;
    endcase
  end

  // Writes to INP / reserved and reads of reserved are flagged.
  always_comb begin
    if (wen) bad = (sel == GPIO_INP[3:2]) || (sel == GPIO_RSV[3:2]);
    else     bad = (sel == GPIO_RSV[3:2]);
    if (CFG_MIN != 0) bad = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r <= '0;
      ena_r <= '0;
    end else if (trn && wen) begin
      if (sel == GPIO_OUT[3:2]) out_r <= out_nxt;
      if (sel == GPIO_ENA[3:2]) ena_r <= ena_nxt;
    end
  end

  // Response registers; rdt holds across cycles without a read, err is
  // a per-response flag and returns to OKAY when nothing was transferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdt   <= '0;
      sts_r <= TCB_OKAY;
    end else begin
      if (trn && !wen) rdt <= rd_val;
      sts_r <= (trn && bad) ? TCB_ERROR : TCB_OKAY;
    end
  end

  assign err    = (sts_r == TCB_ERROR);
  assign gpio_o = out_r;
  assign gpio_e = ena_r;

endmodule

// File: tb/tb_tcb_gpio.sv
module tb_tcb_gpio;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vld = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] adr = '0;
  logic [3:0]  ben = '0;
  logic [31:0] wdt = '0;
  logic        rdy;
  logic [31:0] rdt;
  logic        err;
  logic [31:0] gpio_o;
  logic [31:0] gpio_e;
  logic [31:0] gpio_i = '0;

  int vectors = 0;
  int miscompares = 0;

  tcb_gpio #(
    .GW(32), .ADR(32), .DAT(32), .CFG_CDC(2), .CFG_MIN(0), .CHIP("")
  ) dut (
    .clk(clk), .rst(rst), .vld(vld), .wen(wen), .adr(adr), .ben(ben),
    .wdt(wdt), .rdy(rdy), .rdt(rdt), .err(err),
    .gpio_o(gpio_o), .gpio_e(gpio_e), .gpio_i(gpio_i)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer: driven at a falling edge, taken at the rising edge,
  // response sampled at the following falling edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d);
    @(negedge clk);
    vld = 1'b1; wen = w; adr = a; ben = b; wdt = d;
    @(negedge clk);
    vld = 1'b0; wen = 1'b0; ben = '0; wdt = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_gpio_o", gpio_o, 32'h0);
    chk("rst_gpio_e", gpio_e, 32'h0);
    chk("rst_rdt", rdt, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rdy_tied", {31'b0, rdy}, 32'h1);
    @(negedge clk);
    rst = 1'b1;

    // reads after reset
    xfer(1'b0, 32'h00, 4'hf, 32'h0);
    chk("rd_out_rst", rdt, 32'h0);
    chk("rd_out_rst_err", {31'b0, err}, 32'h0);
    xfer(1'b0, 32'h04, 4'hf, 32'h0);
    chk("rd_ena_rst", rdt, 32'h0);

    // full-word writes and readback
    xfer(1'b1, 32'h00, 4'hf, 32'h01234567);
    chk("wr_out_err", {31'b0, err}, 32'h0);
    xfer(1'b1, 32'h04, 4'hf, 32'h76543210);
    chk("gpio_o_wr", gpio_o, 32'h01234567);
    chk("gpio_e_wr", gpio_e, 32'h76543210);
    xfer(1'b0, 32'h00, 4'h0, 32'h0);
    chk("rd_out", rdt, 32'h01234567);
    xfer(1'b0, 32'h04, 4'h0, 32'h0);
    chk("rd_ena", rdt, 32'h76543210);

    // input path through the synchronizer
    gpio_i = 32'h89abcdef;
    idle(2);
    xfer(1'b0, 32'h08, 4'hf, 32'h0);
    chk("rd_inp_a", rdt, 32'h89abcdef);
    chk("rd_inp_a_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    gpio_i = 32'hfedcba98;
    vld = 1'b1; wen = 1'b0; adr = 32'h08; ben = 4'hf;
    @(negedge clk);
    vld = 1'b0;
    chk("rd_inp_sync_lag", rdt, 32'h89abcdef);
    idle(1);
    xfer(1'b0, 32'h08, 4'hf, 32'h0);
    chk("rd_inp_b", rdt, 32'hfedcba98);

    // byte-enable write; rdt holds the previous read
    xfer(1'b1, 32'h00, 4'b0010, 32'hffffffff);
    chk("ben_gpio_o", gpio_o, 32'h0123ff67);
    chk("rdt_hold", rdt, 32'hfedcba98);
    xfer(1'b1, 32'h04, 4'b0000, 32'hffffffff);
    chk("ben_none", gpio_e, 32'h76543210);

    // error cases
    xfer(1'b1, 32'h08, 4'hf, 32'hdeadbeef);
    chk("wr_inp_err", {31'b0, err}, 32'h1);
    chk("wr_inp_o", gpio_o, 32'h0123ff67);
    chk("wr_inp_e", gpio_e, 32'h76543210);
    xfer(1'b0, 32'h0c, 4'hf, 32'h0);
    chk("rd_rsv_err", {31'b0, err}, 32'h1);
    chk("rd_rsv_rdt", rdt, 32'h0);
    xfer(1'b1, 32'h0c, 4'hf, 32'h5a5a5a5a);
    chk("wr_rsv_err", {31'b0, err}, 32'h1);
    chk("wr_rsv_o", gpio_o, 32'h0123ff67);
    xfer(1'b0, 32'h08, 4'hf, 32'h0);
    chk("rd_inp_noerr", {31'b0, err}, 32'h0);

    // upper address bits alias
    xfer(1'b0, 32'h10, 4'hf, 32'h0);
    chk("rd_alias", rdt, 32'h0123ff67);

    // reset in the middle of a read
    @(negedge clk);
    vld = 1'b1; wen = 1'b0; adr = 32'h04; ben = 4'hf;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_o", gpio_o, 32'h0);
    chk("mid_rst_e", gpio_e, 32'h0);
    chk("mid_rst_rdt", rdt, 32'h0);
    @(negedge clk);
    vld = 1'b0;
    chk("mid_rst_no_rsp", rdt, 32'h0);
    chk("mid_rst_err", {31'b0, err}, 32'h0);
    rst = 1'b1;
    xfer(1'b0, 32'h08, 4'hf, 32'h0);
    chk("post_rst_inp", rdt, 32'h0);
    xfer(1'b0, 32'h00, 4'hf, 32'h0);
    chk("post_rst_out", rdt, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
